// File: rtl/apb_requester_if.sv
// ---------------------------------------------------------------------------
// apb_requester_if
//   APB bus bundle between one requester (manager) and one subordinate.
//
//   Parameters
//     ADDR_WIDTH  width of PADDR
//     DATA_WIDTH  width of PWDATA / PRDATA
//
//   Signals
//     PSELx    requester -> subordinate  select
//     PENABLE  requester -> subordinate  ACCESS phase marker
//     PWRITE   requester -> subordinate  1 = write, 0 = read
//     PADDR    requester -> subordinate  address
//     PWDATA   requester -> subordinate  write data
//     PRDATA   subordinate -> requester  read data
//     PREADY   subordinate -> requester  transfer done / no more wait states
//     PSLVERR  subordinate -> requester  error, meaningful only with PREADY
//
//   Modports
//     master  the requester side
//     slave   the subordinate side
// ---------------------------------------------------------------------------
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
//   APB requester (manager). Takes one command at a time on a valid/ready
//   port, runs it through the IDLE -> SETUP -> ACCESS phases on the APB bus,
//   waits for PREADY and returns PRDATA/PSLVERR as a one-cycle response pulse.
//
//   Optional feature (compile-time macro APB_TIMEOUT_EN):
//     when defined, an ACCESS phase that sees TIMEOUT_CYCLES consecutive
//     cycles without PREADY is aborted with rsp_err=1, rsp_rdata=0.
//     When undefined, ACCESS waits on PREADY forever.
//
//   Parameters
//     ADDR_WIDTH      APB address width
//     DATA_WIDTH      APB data width
//     TIMEOUT_CYCLES  ACCESS cycles without PREADY before abort (timeout build)
//
//   Ports
//     PCLK       in   clock, rising edge
//     PRESETn    in   asynchronous active-low reset
//     cmd_valid  in   command present
//     cmd_ready  out  requester idle, command will be taken this cycle
//     cmd_write  in   1 = write, 0 = read
//     cmd_addr   in   target address
//     cmd_wdata  in   write data (ignored for reads)
//     rsp_valid  out  one-cycle pulse: transfer finished
//     rsp_rdata  out  read data (0 for writes and timeouts), held until next completion
//     rsp_err    out  PSLVERR or timeout, held until next completion
//     apb        apb_requester_if.master  APB bus
// ---------------------------------------------------------------------------
module apb_requester #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    apb_requester_if.master       apb
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen during the last ACCESS cycle that may still wait.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
`endif

    // Only IDLE can take a command; anything offered in other states is
    // simply left pending by the issuer.
    assign cmd_ready = (state == ST_IDLE);

    // NOTE: every register below is updated with non-blocking assignments so
    // all state changes at one edge see the same pre-edge values; blocking
    // assignments here would make the result depend on statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            // NOTE: rsp_valid defaults low every cycle; only the completing
            // edge raises it, which makes it a single-cycle pulse.
            rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        apb.PWRITE  <= cmd_write;
                        apb.PADDR   <= cmd_addr;
                        apb.PWDATA  <= cmd_write ? cmd_wdata : '0;
                        apb.PSELx   <= 1'b1;
                        apb.PENABLE <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                end

                ST_ACCESS: begin
                    if (apb.PREADY) begin
                        // PREADY wins even on the last counted cycle.
                        rsp_valid   <= 1'b1;
                        rsp_err     <= apb.PSLVERR;
                        rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                        apb.PSELx   <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= ST_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        apb.PSELx   <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    apb.PSELx   <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
